// File: rtl/ram_arbiter.sv
// Two-requester, single-port RAM arbiter.
// A four-state FSM (IDLE/ACCESS/RESP/DONE) serves one request at a time.
// The request is latched at grant. The RAM's registered read data is captured
// one cycle after the access. Completion is a one-cycle done pulse, qualified
// by err for out-of-range addresses.
module ram_arbiter #(
  parameter int          DEPTH    = 100,
  parameter logic [31:0] ERR_CODE = 32'hDEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        rw0,
  input  logic        rw1,
  input  logic [6:0]  addr0,
  input  logic [6:0]  addr1,
  input  logic [31:0] din0,
  input  logic [31:0] din1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [6:0]  ram_addr,
  output logic        ram_rw,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_out
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_gnt_vld;
  logic        w_gnt_id;
  logic        w_oor;

  // r_last_grant doubles as the identity of the requester being served
  logic        r_last_grant;
  logic        r_rw;
  logic [6:0]  r_addr;
  logic [31:0] r_din;
  logic [31:0] r_rdata;
  logic        r_err;

  assign w_oor = ({25'd0, r_addr} >= DEPTH_U);

  // The latched address/data only change at a grant, which is also the edge
  // entering ACCESS, so they double as the "last driven" RAM address/data.
  assign ram_addr = r_addr;
  assign ram_din  = r_din;
  assign rdata    = r_rdata;
  assign err      = r_err;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, round-robin grant decision and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_vld   = 1'b0;
    w_gnt_id    = r_last_grant;
    busy        = 1'b1;
    done0       = 1'b0;
    done1       = 1'b0;
    ram_rw      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (req0 || req1) begin
          w_gnt_vld   = 1'b1;
          w_state_nxt = S_ACCESS;
          if (req0 && req1) w_gnt_id = ~r_last_grant;
          else              w_gnt_id = req1;
        end
      end
      S_ACCESS: begin
        ram_rw      = r_rw && !w_oor;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done0       = (r_last_grant == 1'b0);
        done1       = (r_last_grant == 1'b1);
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Latch the granted requester's transaction; reset sets last grant to 1 so
  // requester 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
    end else if (w_gnt_vld) begin
      r_last_grant <= w_gnt_id;
      r_rw         <= w_gnt_id ? rw1   : rw0;
      r_addr       <= w_gnt_id ? addr1 : addr0;
      r_din        <= w_gnt_id ? din1  : din0;
    end
  end

  // Capture the response on the RESP->DONE edge; it holds until the next one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (r_state == S_RESP) begin
      r_rdata <= w_oor ? ERR_CODE : ram_out;
      r_err   <= w_oor;
    end
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DEPTH, default 100, number of valid RAM words; addresses 0..DEPTH-1 are legal.
REQ-002 Parameter ERR_CODE, default 32'hDEAD, read data returned for an out-of-range address.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0, req1  input  1 each  access request from requester 0 / 1.
REQ-006 rw0, rw1  input  1 each  access type: 1 = write, 0 = read.
REQ-007 addr0, addr1  input  7 each  word address.
REQ-008 din0, din1  input  32 each  write data.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-010 err  output  1  qualifies the active done pulse: 1 = address out of range.
REQ-011 rdata  output  32  response data, valid while a done pulse is high.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 ram_addr  output  7  RAM address.
REQ-014 ram_rw  output  1  RAM write enable.
REQ-015 ram_din  output  32  RAM write data.
REQ-016 ram_out  input  32  RAM registered read data; RAM output is valid one clock after its address is sampled.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP, DONE; IDLE->ACCESS on grant, ACCESS->RESP, RESP->DONE, DONE->IDLE; no other transitions.
REQ-018 In IDLE with any req high, grant exactly one requester and latch its rw, addr and din into internal registers at that edge.
REQ-019 Arbitration: with only one req high, grant it; with both high, grant the requester not granted last (round-robin); a last_grant register updates on each grant.
REQ-020 Request inputs are ignored outside IDLE; latched values alone drive the transaction.
REQ-021 In ACCESS: ram_addr = latched addr, ram_din = latched din, ram_rw = latched rw only if addr < DEPTH, else 0.
REQ-022 In every state other than ACCESS: ram_rw = 0; ram_addr and ram_din hold their last driven values.
REQ-023 At the RESP->DONE edge: rdata <= ERR_CODE if addr >= DEPTH, else ram_out; err <= (addr >= DEPTH).
REQ-024 In DONE: done of the granted requester = 1 for exactly one cycle; the other done = 0.
REQ-025 For a write, rdata carries the RAM contents before the write (RAM read-before-write).
REQ-026 Latency: req sampled in IDLE at cycle N -> done high in cycle N+3; next grant no earlier than the edge ending cycle N+4 (one access per 4 cycles).
REQ-027 A requester holding req high through its done cycle is treated as a new request in the following IDLE, subject to REQ-019.
REQ-028 Out-of-range access: no RAM write occurs, latency is unchanged, err = 1 with done.
REQ-029 Address 127 (7-bit max) and address DEPTH are both out of range; address DEPTH-1 is in range.
REQ-030 rdata and err hold their values after done falls until the next RESP->DONE edge.

Reset
REQ-031 rst high asynchronously forces: state IDLE, done0 = done1 = 0, err = 0, rdata = 0, busy = 0, ram_rw = 0, ram_addr = 0, ram_din = 0, last_grant = requester 1 (so requester 0 wins the first tie).
REQ-032 rst asserted mid-transaction aborts it with no done pulse; if rst falls before the ACCESS edge, no RAM write is issued.
REQ-033 The first grant after reset release is evaluated at the first rising edge with rst low.

Verification
REQ-034 req0 write addr 5 din 32'hAABBCCDD, then req0 read addr 5 -> second done0 with rdata = 32'hAABBCCDD, err = 0, 3-cycle latency each.
REQ-035 req0 and req1 both held high continuously -> grants alternate 0,1,0,1; done pulses 4 cycles apart; first grant goes to requester 0.
REQ-036 req1 write addr 100 din 32'h1 -> done1 with err = 1, rdata = 32'hDEAD; ram_rw never high; read of addr 99 returns prior contents unchanged.
REQ-037 Write addr 7 with 32'h11223344 over prior 32'h0 -> done with rdata = 32'h0; a subsequent read returns 32'h11223344.
REQ-038 Assert rst during RESP of a write -> no done pulse, busy = 0 immediately, all outputs at REQ-031 values; the next request completes normally.
REQ-039 req1 alone raised one cycle after a req0 grant -> req1 granted in the IDLE after done0; done1 arrives 4 cycles after done0.
